// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit and receive blocks.
//   tx_state_t      - transmitter FSM state encoding
//   PARITY_*        - values accepted by the PARITY parameter
//   pulse_width()   - clk cycles per bit time (integer division)
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Number of clk cycles in one bit time.
  function automatic int pulse_width(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-time counter, counts 0..PULSE_WIDTH-1 and wraps.
//   clk       in   system clock
//   rst       in   synchronous active-high reset (counter -> 0)
//   restart   in   hold/restart the counter at 0
//   bit_done  out  high in the last cycle of a bit time
//   bit_near  out  high in the second-to-last cycle of a bit time
// PULSE_WIDTH must be at least 2.
module uart_baud_gen #(
  parameter int PULSE_WIDTH = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_done,
  output logic bit_near
);

  localparam int CW = (PULSE_WIDTH > 2) ? $clog2(PULSE_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(PULSE_WIDTH - 1);
  localparam logic [CW-1:0] NEAR = CW'(PULSE_WIDTH - 2);

  logic [CW-1:0] cnt;

  assign bit_done = (cnt == LAST);
  assign bit_near = (cnt == NEAR);

  // Bit-time counter: wraps at the end of every bit, so each new bit
  // (and therefore each FSM state entry from a bit boundary) starts at 0.
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt <= '0;
    end else if (bit_done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter. Takes a word over valid/ready and sends
// start bit, LSB-first data, optional parity and STOP_BITS stop bits.
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   data      in   word to send, sampled on handshake (valid && ready)
//   valid     in   data is offered
//   ready     out  transmitter accepts a word this cycle
//   busy      out  a frame is on the line
//   uart_out  out  serial line, idles high, driven from a flop
module uart_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 115200,
  parameter int CLK_FREQ   = 100_000_000,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  valid,
  output logic                  ready,
  output logic                  busy,
  output logic                  uart_out
);

  import uart_pkg::*;

  localparam int PULSE_WIDTH = pulse_width(CLK_FREQ, BAUD_RATE);
  localparam logic [3:0] LAST_DATA = 4'(DATA_WIDTH - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  tx_state_t             state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [3:0]            bit_cnt;
  logic                  parity_bit;
  logic                  bit_done;
  logic                  bit_near;
  logic                  handshake;
  logic                  last_stop;

  assign handshake = valid && ready;
  assign last_stop = (state == STOP) && (bit_cnt == LAST_STOP);

  // Counter is held at 0 while idle so START always gets a full bit time.
  uart_baud_gen #(
    .PULSE_WIDTH(PULSE_WIDTH)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .restart  (state == IDLE),
    .bit_done (bit_done),
    .bit_near (bit_near)
  );

  // Transmit FSM with registered line, ready and busy outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      uart_out   <= 1'b1;
      ready      <= 1'b0;
      busy       <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= 4'd0;
      parity_bit <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (handshake) begin
            shreg      <= data;
            parity_bit <= (PARITY == PARITY_ODD) ? ~^data : ^data;
            state      <= START;
            uart_out   <= 1'b0;
            ready      <= 1'b0;
            busy       <= 1'b1;
          end else begin
            uart_out   <= 1'b1;
            ready      <= 1'b1;
            busy       <= 1'b0;
          end
        end

        START: begin
          if (bit_done) begin
            state    <= DATA;
            uart_out <= shreg[0];
            bit_cnt  <= 4'd0;
          end
        end

        DATA: begin
          if (bit_done) begin
            shreg <= shreg >> 1;
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= 4'd0;
              if (PARITY != PARITY_NONE) begin
                state    <= uart_pkg::PARITY;
                uart_out <= parity_bit;
              end else begin
                state    <= STOP;
                uart_out <= 1'b1;
              end
            end else begin
              bit_cnt  <= bit_cnt + 4'd1;
              // shreg[1] is the next bit once this shift lands.
              uart_out <= shreg[1];
            end
          end
        end

        uart_pkg::PARITY: begin
          if (bit_done) begin
            state    <= STOP;
            uart_out <= 1'b1;
            bit_cnt  <= 4'd0;
          end
        end

        STOP: begin
          // Open ready for the final cycle of the last stop bit so a
          // waiting word can follow with no idle gap.
          if (last_stop && bit_near) begin
            ready <= 1'b1;
          end
          if (bit_done) begin
            if (last_stop) begin
              if (handshake) begin
                shreg      <= data;
                parity_bit <= (PARITY == PARITY_ODD) ? ~^data : ^data;
                state      <= START;
                uart_out   <= 1'b0;
                ready      <= 1'b0;
              end else begin
                state      <= IDLE;
                uart_out   <= 1'b1;
                busy       <= 1'b0;
              end
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end

        default: begin
          state    <= IDLE;
          uart_out <= 1'b1;
          ready    <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx.
//   dut_d : default parameters (868 cycles per bit)
//   dut_f : 8 cycles per bit, no parity, 1 stop bit
//   dut_p : 8 cycles per bit, odd parity, 2 stop bits
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_d, data_f, data_p;
  logic       valid_d, valid_f, valid_p;
  logic       ready_d, ready_f, ready_p;
  logic       busy_d, busy_f, busy_p;
  logic       out_d, out_f, out_p;

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [9:0] rx;
  logic [11:0] rxp;
  int         ready_hi;
  int         high_cnt;
  int         w;
  int         sent, got, cyc, start_cyc, idx;
  logic       hs_prev;
  logic [9:0] fr;

  always #5 clk = ~clk;

  uart_tx dut_d (
    .clk(clk), .rst(rst), .data(data_d), .valid(valid_d),
    .ready(ready_d), .busy(busy_d), .uart_out(out_d)
  );

  uart_tx #(.CLK_FREQ(800), .BAUD_RATE(100)) dut_f (
    .clk(clk), .rst(rst), .data(data_f), .valid(valid_f),
    .ready(ready_f), .busy(busy_f), .uart_out(out_f)
  );

  uart_tx #(.CLK_FREQ(800), .BAUD_RATE(100), .PARITY(2), .STOP_BITS(2)) dut_p (
    .clk(clk), .rst(rst), .data(data_p), .valid(valid_p),
    .ready(ready_p), .busy(busy_p), .uart_out(out_p)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Send one word on dut_f, changing data to d_after right after the
  // handshake, and sample the 10 line bits at mid-bit.
  task automatic tx_f(input logic [7:0] d, input logic [7:0] d_after, output logic [9:0] bits);
    int t;
    data_f  = d;
    valid_f = 1'b1;
    t = 0;
    while (!ready_f && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("hs_f_ready", {31'd0, ready_f}, 32'd1);
    @(negedge clk);
    data_f  = d_after;
    valid_f = 1'b0;
    bits = 10'd0;
    for (int i = 0; i < 80; i++) begin
      if (i % 8 == 4) bits[i/8] = out_f;
      @(negedge clk);
    end
  endtask

  // Send one word on dut_p (odd parity, 2 stop bits) and check parity,
  // stop length and frame length.
  task automatic tx_p(input logic [7:0] d, input logic exp_par);
    int t;
    data_p  = d;
    valid_p = 1'b1;
    t = 0;
    while (!ready_p && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("hs_p_ready", {31'd0, ready_p}, 32'd1);
    @(negedge clk);
    valid_p  = 1'b0;
    rxp      = 12'd0;
    high_cnt = 0;
    for (int i = 0; i <= 96; i++) begin
      if (i % 8 == 4 && i < 96) rxp[i/8] = out_p;
      if (i >= 80 && i < 96 && out_p) high_cnt++;
      if (i == 95) begin
        check("par_ready_last", {31'd0, ready_p}, 32'd1);
        check("par_busy_last", {31'd0, busy_p}, 32'd1);
      end
      if (i == 96) check("par_busy_end", {31'd0, busy_p}, 32'd0);
      if (i < 96) @(negedge clk);
    end
    check("par_bit", {31'd0, rxp[9]}, {31'd0, exp_par});
    check("par_stop_high", high_cnt, 32'd16);
    check("par_frame", {20'd0, rxp}, {20'd0, 2'b11, exp_par, d, 1'b0});
  endtask

  initial begin
    rst = 1'b1;
    valid_d = 1'b1; data_d = 8'hA5;
    valid_f = 1'b0; data_f = 8'h00;
    valid_p = 1'b0; data_p = 8'h00;

    // Reset values, with valid held high throughout reset.
    repeat (3) @(negedge clk);
    check("rst_out_d", {31'd0, out_d}, 32'd1);
    check("rst_ready_d", {31'd0, ready_d}, 32'd0);
    check("rst_busy_d", {31'd0, busy_d}, 32'd0);
    check("rst_out_f", {31'd0, out_f}, 32'd1);
    check("rst_ready_f", {31'd0, ready_f}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_out_d", {31'd0, out_d}, 32'd1);
    check("rel_busy_d", {31'd0, busy_d}, 32'd0);
    check("rel_ready_d", {31'd0, ready_d}, 32'd1);
    @(negedge clk);
    // Handshake took place on the edge just passed.
    check("hs_start_d", {31'd0, out_d}, 32'd0);
    check("hs_busy_d", {31'd0, busy_d}, 32'd1);
    check("hs_ready_d", {31'd0, ready_d}, 32'd0);
    valid_d = 1'b0;
    data_d  = 8'h00;

    // 0xA5 at defaults: 10 bits x 868 cycles.
    ready_hi = 0;
    rx = 10'd0;
    for (int i = 0; i <= 8680; i++) begin
      if (i % 868 == 434) rx[i/868] = out_d;
      if (i < 8679 && ready_d) ready_hi++;
      if (i == 8679) begin
        check("d_ready_last", {31'd0, ready_d}, 32'd1);
        check("d_busy_last", {31'd0, busy_d}, 32'd1);
      end
      if (i == 8680) begin
        check("d_busy_end", {31'd0, busy_d}, 32'd0);
        check("d_out_end", {31'd0, out_d}, 32'd1);
      end
      if (i < 8680) @(negedge clk);
    end
    check("d_frame_a5", {22'd0, rx}, {22'd0, 10'b1_1010_0101_0});
    check("d_ready_in_frame", ready_hi, 32'd0);

    // Data changed after handshake does not affect the frame.
    tx_f(8'h55, 8'hFF, rx);
    check("f_frame_55", {22'd0, rx}, {22'd0, 1'b1, 8'h55, 1'b0});

    // Reset during data bit 3 of 0x00.
    data_f  = 8'h00;
    valid_f = 1'b1;
    w = 0;
    while (!ready_f && w < 50) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    valid_f = 1'b0;
    repeat (35) @(negedge clk);
    check("mid_line_low", {31'd0, out_f}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_out", {31'd0, out_f}, 32'd1);
    check("mid_rst_busy", {31'd0, busy_f}, 32'd0);
    check("mid_rst_ready", {31'd0, ready_f}, 32'd0);
    @(negedge clk);
    check("mid_rel_ready", {31'd0, ready_f}, 32'd1);
    check("mid_rel_out", {31'd0, out_f}, 32'd1);
    tx_f(8'h3C, 8'h3C, rx);
    check("f_frame_3c", {22'd0, rx}, {22'd0, 1'b1, 8'h3C, 1'b0});

    // Odd parity, two stop bits.
    tx_p(8'h07, 1'b0);
    tx_p(8'h03, 1'b1);

    // Back-to-back sweep 0x00..0xFF with valid held; frames must tile
    // the line every 80 cycles with no gap.
    sent = 0; got = 0; cyc = 0; start_cyc = -1; hs_prev = 1'b0; fr = 10'd0;
    data_f  = 8'h00;
    valid_f = 1'b1;
    while (got < 256 && cyc < 256 * 80 + 200) begin
      @(negedge clk);
      cyc++;
      if (hs_prev) begin
        if (start_cyc < 0) start_cyc = cyc;
        sent++;
        if (sent == 256) valid_f = 1'b0;
        else data_f = 8'(sent);
      end
      hs_prev = valid_f && ready_f;
      if (start_cyc >= 0) begin
        idx = cyc - start_cyc;
        if (idx % 8 == 4) fr[(idx / 8) % 10] = out_f;
        if (idx % 80 == 76) begin
          check("loop_frame", {22'd0, fr}, {22'd0, 1'b1, 8'(got), 1'b0});
          got++;
        end
      end
    end
    check("loop_count", got, 32'd256);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
